// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide engine with HI/LO result
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state, state_d;

    logic             op_q;
    logic             sign_q;
    logic             sign_r;
    logic             dbz_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             x_neg;
    logic             y_neg;
    logic             divz;
    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign x_neg = is_signed & x[WIDTH-1];
    assign y_neg = is_signed & y[WIDTH-1];
    assign x_abs = x_neg ? -x : x;
    assign y_abs = y_neg ? -y : y;
    assign divz  = op & (y == '0);

    // opnd holds the multiplicand (mul) or divisor (div); acc_lo holds multiplier or quotient
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = sign_q ? -prod : prod;
    assign quot_fix = sign_q ? -acc_lo : acc_lo;
    assign rem_fix  = sign_r ? -acc_hi : acc_hi;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = divz ? FINISH : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dbz_q       <= 1'b0;
            cnt         <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_q <= x_neg ^ y_neg;
                        sign_r <= x_neg;
                        dbz_q  <= divz;
                        cnt    <= '0;
                        opnd   <= op ? y_abs : x_abs;
                        acc_lo <= op ? x_abs : y_abs;
                        // divide-by-zero reports the raw dividend in hi
                        acc_hi <= divz ? x : '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (!op_q) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= rem_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    done        <= 1'b1;
                    div_by_zero <= dbz_q;
                    if (dbz_q) begin
                        hi <= acc_hi;
                        lo <= '1;
                    end else if (!op_q) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against a 64-bit arithmetic model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic        is_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        scb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    logic        last_dbz = 1'b0;
    logic        prev_done = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .is_signed(is_signed),
        .x(x),
        .y(y),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // returns {div_by_zero, hi, lo}
    function automatic logic [64:0] model(input logic o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] v;
        logic [63:0] w;
        if (o && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        if (!o) begin
            v = sa * sb;
            return {1'b0, v};
        end
        v = sa / sb;
        w = sa % sb;
        return {1'b0, w[31:0], v[31:0]};
    endfunction

    task automatic issue(input logic o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit track);
        int          n;
        exp_t        e;
        logic [64:0] m;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_wait: busy=1 after 100 cycles, required 0");
        end
        op = o;
        is_signed = s;
        x = a;
        y = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            m = model(o, s, a, b);
            e.dbz = m[64];
            e.hi = m[63:32];
            e.lo = m[31:0];
            e.due = cyc + ((o && b == 32'd0) ? 1 : 33);
            scb.push_back(e);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_hi = '0;
            last_lo = '0;
            last_dbz = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("busy_with_done", {64'd0, busy}, 65'd0);
                check("done_twice", {64'd0, prev_done}, 65'd0);
                if (scb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done=1 with no operation outstanding");
                end else begin
                    e = scb.pop_front();
                    check("result", {div_by_zero, hi, lo}, {e.dbz, e.hi, e.lo});
                    check("done_cycle", 65'(cyc), 65'(e.due));
                    last_hi = e.hi;
                    last_lo = e.lo;
                    last_dbz = e.dbz;
                end
            end else begin
                check("hold", {div_by_zero, hi, lo}, {last_dbz, last_hi, last_lo});
            end
            prev_done = done;
        end
    end

    initial begin
        int n;
        logic o;
        rst = 1'b1;
        start = 1'b0;
        op = 1'b0;
        is_signed = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {60'd0, busy, done, div_by_zero, (hi != 0), (lo != 0)}, 65'd0);
        #2 rst = 1'b0;

        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6, 1'b1);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
        issue(1'b1, 1'b0, 32'h1234_5678, 32'd0, 1'b1);
        issue(1'b0, 1'b0, 32'd3, 32'd3, 1'b1);
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // start held during a run must not disturb the operation in flight
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        x = $urandom;
        y = $urandom;
        repeat (10) @(negedge clk);
        start = 1'b0;

        issue(1'b0, 1'b0, $urandom, $urandom, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_state", {60'd0, busy, done, div_by_zero, (hi != 0), (lo != 0)}, 65'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        issue(1'b0, 1'b0, 32'd3, 32'd5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            issue(o, 1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
        end

        n = 0;
        while (scb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (scb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", scb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
